// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO serial frame receiver.
//  siso_rx_state_t : receiver FSM states
//  DIR_LSB_FIRST   : dir value selecting first bit -> word bit 0
//  DIR_MSB_FIRST   : dir value selecting first bit -> word bit WIDTH-1
package siso_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      FULL    = 2'd2,
      DISCARD = 2'd3
   } siso_rx_state_t;

   localparam logic DIR_LSB_FIRST = 1'b1;
   localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/siso_word_slot.sv
// Single-word valid/ready holding register (output stage of the receiver).
//  clk, rst   : clock, synchronous active-high reset
//  load       : capture load_data this edge (caller guarantees slot empty or accepting)
//  load_data  : word to capture
//  ready      : consumer ready; valid & ready accepts the held word
//  valid      : a word is held
//  data       : held word, stable while valid
module siso_word_slot #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A load on the same edge as an accept keeps valid high with the new word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/siso_frame_receiver.sv
// Serial-to-parallel receiver for the SISO link. One bit is sampled per clk while
// sin_vld is high; each run of WIDTH contiguous bits forms a word, which is
// presented on a valid/ready port. Storage is two words: the output slot plus sreg.
//  clk, rst    : clock, synchronous active-high reset
//  sin         : serial data bit
//  sin_vld     : bit strobe
//  dir         : 1 LSB-first, 0 MSB-first (sampled on the first bit of a frame)
//  word_data   : received word, stable while word_valid
//  word_valid  : word available
//  word_ready  : consumer accepts on word_valid & word_ready
//  frame_err   : one-cycle pulse, frame truncated
//  overflow    : one-cycle pulse per bit dropped under backpressure
//  bit_cnt     : bits captured in the current frame
module siso_frame_receiver
   import siso_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_vld,
   input  logic             dir,
   output logic [WIDTH-1:0] word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             frame_err,
   output logic             overflow,
   output logic [CW-1:0]    bit_cnt
);

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   siso_rx_state_t   state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             drop_q, drop_d;
   logic             ferr_q, ferr_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             shift_dir;
   logic [WIDTH-1:0] shifted;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b,
                                                 input logic d);
      if (d == DIR_LSB_FIRST) begin
         return {b, s[WIDTH-1:1]};
      end
      return {s[WIDTH-2:0], b};
   endfunction

   assign accept    = word_valid & word_ready;
   // The first bit of a frame uses the live dir; later bits use the latched copy.
   assign shift_dir = (state_q == IDLE) ? dir : dir_q;
   assign shifted   = shift_in(sreg_q, sin, shift_dir);

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      drop_d    = drop_q;
      ferr_d    = 1'b0;
      ovf_d     = 1'b0;
      load      = 1'b0;
      load_data = sreg_q;
      unique case (state_q)
         IDLE: begin
            if (sin_vld) begin
               sreg_d  = shifted;
               dir_d   = dir;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_vld) begin
               sreg_d = shifted;
               if (cnt_q == CNT_LAST) begin
                  if (!word_valid || accept) begin
                     load      = 1'b1;
                     load_data = shifted;
                     cnt_d     = '0;
                     state_d   = IDLE;
                  end else begin
                     // Slot busy: park the complete word in sreg.
                     cnt_d   = CNT_FULL;
                     state_d = FULL;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               ferr_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         FULL: begin
            if (sin_vld) begin
               ovf_d  = 1'b1;
               drop_d = 1'b1;
            end
            if (accept) begin
               load      = 1'b1;
               load_data = sreg_q;
               cnt_d     = '0;
               // Any drop means we are mid-frame; skip to the next frame boundary.
               state_d   = (drop_q || sin_vld) ? DISCARD : IDLE;
            end
         end
         DISCARD: begin
            if (sin_vld) begin
               ovf_d = 1'b1;
            end else begin
               drop_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_LSB_FIRST;
         drop_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         drop_q  <= drop_d;
         ferr_q  <= ferr_d;
         ovf_q   <= ovf_d;
      end
   end

   siso_word_slot #(
      .WIDTH(WIDTH)
   ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_data(load_data),
      .ready    (word_ready),
      .valid    (word_valid),
      .data     (word_data)
   );

   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_siso_frame_receiver.sv
// Bench for siso_frame_receiver with WIDTH=8: directed vector table, hand-written
// corner sequences, and randomized traffic checked against a queue-based model.
module tb_siso_frame_receiver;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sin = 1'b0;
   logic          sin_vld = 1'b0;
   logic          dir = 1'b1;
   logic [W-1:0]  word_data;
   logic          word_valid;
   logic          word_ready = 1'b0;
   logic          frame_err;
   logic          overflow;
   logic [CW-1:0] bit_cnt;

   int checks = 0;
   int errors = 0;
   int obs_ovf = 0;
   int obs_ferr = 0;

   always #5 clk = ~clk;

   siso_frame_receiver #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_vld   (sin_vld),
      .dir       (dir),
      .word_data (word_data),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .frame_err (frame_err),
      .overflow  (overflow),
      .bit_cnt   (bit_cnt)
   );

   // Reference model: words held (front = presented, second = parked), bits of the
   // frame in progress, and whether we are skipping the rest of an overrun frame.
   logic [W-1:0] m_q[$];
   bit           m_bits[$];
   bit           m_dir;
   bit           m_drop;
   bit           m_skip;
   logic [W-1:0] m_out;
   bit           m_ferr;
   bit           m_ovf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] build_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (m_dir) w[i] = m_bits[i];
         else       w[W-1-i] = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_step(input bit r, input bit v, input bit s, input bit d, input bit rd);
      bit acc;
      m_ferr = 0;
      m_ovf  = 0;
      if (r) begin
         m_q.delete();
         m_bits.delete();
         m_drop = 0;
         m_skip = 0;
         m_out  = '0;
         return;
      end
      acc = (m_q.size() > 0) && rd;
      if (m_q.size() == 2) begin
         if (v) begin
            m_ovf  = 1;
            m_drop = 1;
         end
         if (acc) begin
            void'(m_q.pop_front());
            m_skip = m_drop;
            m_drop = 0;
         end
      end else if (m_skip) begin
         if (acc) void'(m_q.pop_front());
         if (v) m_ovf = 1;
         else   m_skip = 0;
      end else begin
         if (acc) void'(m_q.pop_front());
         if (v) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(s);
            if (m_bits.size() == int'(W)) begin
               m_q.push_back(build_word());
               m_bits.delete();
            end
         end else if (m_bits.size() > 0) begin
            m_ferr = 1;
            m_bits.delete();
         end
      end
      if (m_q.size() > 0) m_out = m_q[0];
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input bit r, input bit v, input bit s, input bit d, input bit rd);
      int exp_cnt;
      rst        = r;
      sin_vld    = v;
      sin        = s;
      dir        = d;
      word_ready = rd;
      model_step(r, v, s, d, rd);
      @(posedge clk);
      #1;
      obs_ovf  += int'(overflow);
      obs_ferr += int'(frame_err);
      exp_cnt = (m_q.size() == 2) ? int'(W) : m_bits.size();
      chk("model_valid", 32'(word_valid), 32'(m_q.size() > 0));
      chk("model_data", 32'(word_data), 32'(m_out));
      chk("model_bit_cnt", 32'(bit_cnt), 32'(exp_cnt));
      chk("model_frame_err", 32'(frame_err), 32'(m_ferr));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic send(input logic [W-1:0] w, input bit d, input bit rd, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         cycle(0, 1, d ? w[i] : w[W-1-i], d, rd);
      end
   endtask

   typedef struct {
      bit           vld;
      bit           sbit;
      bit           d;
      bit           rdy;
      bit           e_valid;
      logic [W-1:0] e_data;
      int           e_cnt;
   } vec_t;

   vec_t         vecs[18];
   logic [W-1:0] pat;
   logic [W-1:0] w01;
   logic [W-1:0] w80;

   initial begin
      // Bit sequence 1,0,1,1,0,0,1,0: pat[i] is the i-th bit on the wire.
      pat = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{1'b1, pat[i], 1'b1, 1'b1, (i == 7), (i == 7) ? 8'h4D : 8'h00,
                     (i == 7) ? 0 : i + 1};
         vecs[9 + i] = '{1'b1, pat[i], (i == 3 || i == 4), 1'b1, (i == 7),
                         (i == 7) ? 8'hB2 : 8'h4D, (i == 7) ? 0 : i + 1};
      end
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 0};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 0};

      // Reset state
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_valid", 32'(word_valid), 0);
      chk("rst_data", 32'(word_data), 0);
      chk("rst_bit_cnt", 32'(bit_cnt), 0);
      chk("rst_flags", 32'({frame_err, overflow}), 0);

      // Tests 1 and 2: LSB-first 4D, MSB-first B2 with dir toggled mid-frame
      for (int i = 0; i < 18; i++) begin
         cycle(0, vecs[i].vld, vecs[i].sbit, vecs[i].d, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i), 32'(word_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_data", i), 32'(word_data), 32'(vecs[i].e_data));
         chk($sformatf("vec%0d_bit_cnt", i), 32'(bit_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_flags", i), 32'({frame_err, overflow}), 0);
      end

      // Test 3: truncated frame, then a clean 5A
      send(8'h77, 1, 1, 5);
      chk("t3_cnt5", 32'(bit_cnt), 5);
      cycle(0, 0, 0, 1, 1);
      chk("t3_ferr", 32'(frame_err), 1);
      chk("t3_no_valid", 32'(word_valid), 0);
      chk("t3_cnt0", 32'(bit_cnt), 0);
      cycle(0, 0, 0, 1, 1);
      chk("t3_ferr_pulse", 32'(frame_err), 0);
      send(8'h5A, 1, 1, 8);
      chk("t3_valid", 32'(word_valid), 1);
      chk("t3_data", 32'(word_data), 32'h5A);
      cycle(0, 0, 0, 1, 1);

      // Test 4: backpressure, overflow, discard and recovery
      send(8'hA5, 1, 0, 8);
      send(8'h3C, 1, 0, 8);
      chk("t4_held_data", 32'(word_data), 32'hA5);
      chk("t4_held_valid", 32'(word_valid), 1);
      chk("t4_full_cnt", 32'(bit_cnt), 8);
      cycle(0, 0, 0, 1, 0);
      obs_ovf = 0;
      send(8'hE7, 1, 0, 8);
      chk("t4_ovf_count", 32'(obs_ovf), 8);
      cycle(0, 0, 0, 1, 1);
      chk("t4_second_data", 32'(word_data), 32'h3C);
      chk("t4_second_valid", 32'(word_valid), 1);
      chk("t4_cnt_after_accept", 32'(bit_cnt), 0);
      cycle(0, 0, 0, 1, 1);
      chk("t4_drained", 32'(word_valid), 0);
      cycle(0, 0, 0, 1, 1);
      send(8'hC3, 1, 1, 8);
      chk("t4_c3_data", 32'(word_data), 32'hC3);
      chk("t4_c3_valid", 32'(word_valid), 1);
      cycle(0, 0, 0, 1, 1);

      // Test 5: reset mid-frame with a word held
      send(8'h11, 1, 0, 8);
      send(8'h0F, 1, 0, 3);
      cycle(1, 0, 0, 1, 0);
      chk("t5_rst_outputs", 32'({word_valid, word_data, frame_err, overflow, bit_cnt}), 0);
      send(8'hFF, 1, 1, 8);
      chk("t5_ff_data", 32'(word_data), 32'hFF);
      chk("t5_ff_valid", 32'(word_valid), 1);
      cycle(0, 0, 0, 1, 1);

      // Test 6: zero-gap back-to-back frames 01 then 80
      w01 = 8'h01;
      w80 = 8'h80;
      obs_ovf  = 0;
      obs_ferr = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, (i < 8) ? w01[i] : w80[i-8], 1, 1);
         chk($sformatf("t6_valid%0d", i), 32'(word_valid), 32'(i == 7 || i == 15));
         if (i == 7)  chk("t6_data01", 32'(word_data), 32'h01);
         if (i == 15) chk("t6_data80", 32'(word_data), 32'h80);
      end
      chk("t6_no_flags", 32'(obs_ovf + obs_ferr), 0);
      cycle(0, 0, 0, 1, 1);

      // Randomized traffic: truncated frames, gaps, dir jitter, variable backpressure
      for (int f = 0; f < 200; f++) begin
         int  len;
         int  gap;
         bit  fd;
         int  rdy_pct;
         fd      = 1'($urandom);
         len     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
         gap     = int'($urandom_range(0, 3));
         rdy_pct = (f % 40 < 20) ? 90 : 30;
         for (int i = 0; i < len; i++) begin
            bit dj;
            dj = ($urandom_range(0, 9) == 0) ? ~fd : fd;
            cycle(0, 1, 1'($urandom), dj, $urandom_range(0, 99) < rdy_pct);
         end
         for (int i = 0; i < gap; i++) begin
            cycle(0, 0, 1'($urandom), 1'($urandom), $urandom_range(0, 99) < rdy_pct);
         end
         if (f == 120) cycle(1, 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
